// File: rtl/lms_coef_fir.sv
// Time-multiplexed FIR that applies LMS-adapted coefficients to an independent sample stream.
// One MAC per cycle; coefficient updates are staged in a shadow bank and applied only at sample acceptance.
module lms_coef_fir #(
    parameter int X_W   = 16,
    parameter int W_W   = 16,
    parameter int O_N   = 16,
    parameter int Y_W   = 16,
    parameter int ACC_W = 36,
    parameter int SHIFT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W_W*O_N-1:0]   coef_in,
    input  logic                 coef_up,
    input  logic                 freeze,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic [X_W-1:0]       xin,
    output logic                 y_valid,
    output logic [Y_W-1:0]       yout,
    output logic                 busy
);

    localparam int P_W = X_W + W_W;
    localparam int K_W = (O_N > 1) ? $clog2(O_N) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(O_N - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-Y_W+1){1'b0}}, {(Y_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-Y_W+1){1'b1}}, {(Y_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state, state_nxt;

    logic signed [X_W-1:0]   taps     [O_N];
    logic signed [W_W-1:0]   coef_act [O_N];
    logic signed [W_W-1:0]   coef_shd [O_N];
    logic                    pending;
    logic signed [ACC_W-1:0] acc;
    logic [K_W-1:0]          k;

    logic                    accept;
    logic                    coef_wr;
    logic                    last_tap;
    logic                    mac_en;
    logic                    out_en;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_sh;
    logic [Y_W-1:0]          y_sat;

    assign accept   = x_valid & x_ready;
    assign coef_wr  = coef_up & ~freeze;
    assign last_tap = (k == K_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MAC;
            MAC:     if (last_tap) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        x_ready = 1'b0;
        busy    = 1'b1;
        mac_en  = 1'b0;
        out_en  = 1'b0;
        case (state)
            IDLE: begin
                x_ready = 1'b1;
                busy    = 1'b0;
            end
            MAC:     mac_en = 1'b1;
            OUT:     out_en = 1'b1;
            default: begin
                x_ready = 1'b0;
                busy    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < O_N; i++) begin
                taps[i] <= '0;
            end
        end else if (accept) begin
            taps[0] <= xin;
            for (int unsigned i = 1; i < O_N; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    // The active bank only moves at acceptance; a same-cycle strobe lands in the shadow for the next sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < O_N; i++) begin
                coef_act[i] <= '0;
                coef_shd[i] <= '0;
            end
            pending <= 1'b0;
        end else begin
            if (accept && pending) begin
                coef_act <= coef_shd;
            end
            if (coef_wr) begin
                for (int unsigned i = 0; i < O_N; i++) begin
                    coef_shd[i] <= coef_in[i*W_W +: W_W];
                end
            end
            if (coef_wr) begin
                pending <= 1'b1;
            end else if (accept) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        prod     = P_W'(taps[k]) * P_W'(coef_act[k]);
        prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
    end

    always_comb begin
        acc_sh = acc >>> SHIFT;
        if (acc_sh > Y_MAX) begin
            y_sat = Y_MAX[Y_W-1:0];
        end else if (acc_sh < Y_MIN) begin
            y_sat = Y_MIN[Y_W-1:0];
        end else begin
            y_sat = acc_sh[Y_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            k       <= '0;
            yout    <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= out_en;
            if (accept) begin
                acc <= '0;
                k   <= '0;
            end else if (mac_en) begin
                acc <= acc + prod_ext;
                k   <= k + 1'b1;
            end
            if (out_en) begin
                yout <= y_sat;
            end
        end
    end

endmodule

// File: tb/tb_lms_coef_fir.sv
// Self-checking bench for lms_coef_fir: directed test-plan steps followed by randomized samples,
// all checked against a tap-history/coefficient-bank reference model.
module tb_lms_coef_fir;

    localparam int X_W   = 16;
    localparam int W_W   = 16;
    localparam int O_N   = 16;
    localparam int Y_W   = 16;
    localparam int ACC_W = 36;
    localparam int SHIFT = 15;
    localparam int LAT   = O_N + 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [W_W*O_N-1:0] coef_in = '0;
    logic               coef_up = 1'b0;
    logic               freeze = 1'b0;
    logic               x_valid = 1'b0;
    logic               x_ready;
    logic [X_W-1:0]     xin = '0;
    logic               y_valid;
    logic [Y_W-1:0]     yout;
    logic               busy;

    always #5 clk = ~clk;

    lms_coef_fir #(
        .X_W(X_W), .W_W(W_W), .O_N(O_N), .Y_W(Y_W), .ACC_W(ACC_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .coef_in(coef_in), .coef_up(coef_up), .freeze(freeze),
        .x_valid(x_valid), .x_ready(x_ready), .xin(xin), .y_valid(y_valid), .yout(yout),
        .busy(busy)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int     hist [O_N];
    int     act  [O_N];
    int     shd  [O_N];
    int     nxt  [O_N];
    bit     pend;
    longint last_y;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < O_N; i++) begin
            hist[i] = 0;
            act[i]  = 0;
            shd[i]  = 0;
        end
        pend   = 1'b0;
        last_y = 0;
    endfunction

    function automatic void nxt_clear();
        for (int i = 0; i < O_N; i++) nxt[i] = 0;
    endfunction

    function automatic longint model_y();
        longint sum = 0;
        longint y;
        for (int i = 0; i < O_N; i++) sum += longint'(hist[i]) * longint'(act[i]);
        y = sum >>> SHIFT;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    function automatic void model_strobe();
        if (!freeze) begin
            shd  = nxt;
            pend = 1'b1;
        end
    endfunction

    function automatic void model_accept(input int x);
        for (int i = O_N - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = x;
        if (pend) begin
            act  = shd;
            pend = 1'b0;
        end
    endfunction

    function automatic logic [W_W*O_N-1:0] pack_nxt();
        logic [W_W*O_N-1:0] p;
        int v;
        p = '0;
        for (int i = 0; i < O_N; i++) begin
            v = nxt[i];
            p[i*W_W +: W_W] = v[W_W-1:0];
        end
        return p;
    endfunction

    task automatic strobe_coef();
        @(negedge clk);
        coef_in = pack_nxt();
        coef_up = 1'b1;
        model_strobe();
        @(negedge clk);
        coef_up = 1'b0;
    endtask

    // One sample through the filter; optional coef_up at acceptance or at cycle up_cyc after it.
    task automatic run_sample(input int x, input int up_cyc, input bit up_at_acc);
        int     lat, lowcnt, pulses;
        longint exp_y;
        @(negedge clk);
        check("idle_ready", longint'(x_ready), 1);
        check("idle_busy", longint'(busy), 0);
        check("yout_hold", longint'($signed(yout)), last_y);
        xin     = x[X_W-1:0];
        x_valid = 1'b1;
        if (up_at_acc) begin
            coef_in = pack_nxt();
            coef_up = 1'b1;
        end
        @(posedge clk);
        model_accept(x);
        if (up_at_acc) model_strobe();
        exp_y  = model_y();
        lat    = 0;
        lowcnt = 0;
        pulses = 0;
        for (int n = 1; n <= LAT + 2; n++) begin
            @(negedge clk);
            x_valid = 1'b0;
            coef_up = 1'b0;
            if (y_valid) begin
                pulses++;
                if (lat == 0) lat = n;
            end
            if (!x_ready) lowcnt++;
            if (n == up_cyc) begin
                coef_in = pack_nxt();
                coef_up = 1'b1;
                model_strobe();
            end
        end
        check("latency", longint'(lat), LAT);
        check("ready_low", longint'(lowcnt), LAT - 1);
        check("pulse_count", longint'(pulses), 1);
        check("yout", longint'($signed(yout)), exp_y);
        last_y = exp_y;
    endtask

    task automatic run_reset_mid(input int x, input int rst_cyc);
        int pulses;
        @(negedge clk);
        xin     = x[X_W-1:0];
        x_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        x_valid = 1'b0;
        for (int n = 1; n < rst_cyc; n++) @(negedge clk);
        check("mid_busy", longint'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        check("rst_ready", longint'(x_ready), 1);
        check("rst_busy", longint'(busy), 0);
        check("rst_yvalid", longint'(y_valid), 0);
        check("rst_yout", longint'($signed(yout)), 0);
        rst_n  = 1'b1;
        pulses = 0;
        for (int n = 0; n < LAT + 2; n++) begin
            @(negedge clk);
            if (y_valid) pulses++;
        end
        check("rst_no_pulse", longint'(pulses), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          x;
        logic [15:0] r;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_ready", longint'(x_ready), 1);
        check("reset_busy", longint'(busy), 0);
        check("reset_yvalid", longint'(y_valid), 0);
        check("reset_yout", longint'($signed(yout)), 0);
        rst_n = 1'b1;

        // Impulse / tap order
        nxt_clear();
        nxt[3] = 32'h7FFF;
        strobe_coef();
        run_sample(32'h7FFF, 0, 1'b0);
        run_sample(0, 0, 1'b0);
        run_sample(0, 0, 1'b0);
        run_sample(0, 0, 1'b0);
        check("impulse_out", longint'($signed(yout)), 32766);

        // Gain and floor rounding
        nxt_clear();
        nxt[0] = 32'h4000;
        strobe_coef();
        run_sample(1000, 0, 1'b0);
        check("gain_pos", longint'($signed(yout)), 500);
        run_sample(-1001, 0, 1'b0);
        check("gain_neg", longint'($signed(yout)), -501);

        // Saturation both ways
        for (int i = 0; i < O_N; i++) nxt[i] = 32'h7FFF;
        strobe_coef();
        for (int i = 0; i < O_N; i++) run_sample(32767, 0, 1'b0);
        check("sat_pos", longint'($signed(yout)), 32767);
        for (int i = 0; i < O_N; i++) run_sample(-32768, 0, 1'b0);
        check("sat_neg", longint'($signed(yout)), -32768);

        // Deferred update and last-one-wins
        nxt_clear();
        nxt[0] = 32'h4000;
        strobe_coef();
        nxt[0] = 32'h2000;
        run_sample(800, 5, 1'b0);
        check("defer_cur", longint'($signed(yout)), 400);
        run_sample(800, 0, 1'b0);
        check("defer_next", longint'($signed(yout)), 200);
        nxt[0] = 32'h4000;
        run_sample(800, 5, 1'b0);
        nxt[0] = 32'h1000;
        strobe_coef();
        run_sample(800, 0, 1'b0);
        check("last_wins", longint'($signed(yout)), 100);

        // Strobe coincident with acceptance goes to the next sample
        nxt[0] = 32'h2000;
        run_sample(800, 0, 1'b1);
        check("acc_strobe_cur", longint'($signed(yout)), 100);
        run_sample(800, 0, 1'b0);
        check("acc_strobe_next", longint'($signed(yout)), 200);

        // Freeze: ignored strobes, earlier pending survives
        freeze = 1'b1;
        nxt_clear();
        strobe_coef();
        run_sample(800, 0, 1'b0);
        check("freeze_hold", longint'($signed(yout)), 200);
        freeze = 1'b0;
        nxt[0] = 32'h3000;
        strobe_coef();
        freeze = 1'b1;
        nxt_clear();
        strobe_coef();
        run_sample(800, 0, 1'b0);
        check("freeze_pending", longint'($signed(yout)), 300);
        freeze = 1'b0;
        strobe_coef();
        run_sample(800, 0, 1'b0);
        check("unfreeze_apply", longint'($signed(yout)), 0);

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < O_N; i++) begin
                if (it % 2 == 0) begin
                    r      = 16'($urandom);
                    nxt[i] = int'($signed(r));
                end else begin
                    nxt[i] = int'($urandom_range(0, 8191)) - 4096;
                end
            end
            freeze = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) strobe_coef();
            r = 16'($urandom);
            x = int'($signed(r));
            run_sample(x, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0,
                       1'($urandom_range(0, 3) == 0));
        end
        freeze = 1'b0;

        // Reset mid-MAC clears everything
        nxt_clear();
        nxt[0] = 32'h4000;
        strobe_coef();
        run_sample(1234, 0, 1'b0);
        run_reset_mid(1234, 8);
        run_sample(1234, 0, 1'b0);
        check("post_reset_zero", longint'($signed(yout)), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lms_coef_fir.md
Name: lms_coef_fir

Overview:
- Fixed-structure FIR filter that consumes the adapted coefficient bus (wout) and its update strobe from the LMS filter top.
- Filters an independent sample stream using the latest coefficient snapshot.
- Uses one time-multiplexed multiply-accumulate (MAC) unit, so one output costs O_N+2 cycles.
- Sits downstream of the LMS core: the LMS learns the coefficients, and this block applies them, e.g. to the live audio path.

Parameters:
- X_W, 16, input sample width (signed)
- W_W, 16, coefficient width (signed, Q1.(W_W-1))
- O_N, 16, number of taps
- Y_W, 16, output sample width (signed)
- ACC_W, 36, accumulator width; must be >= X_W+W_W+clog2(O_N)
- SHIFT, 15, arithmetic right shift applied to the accumulator before saturation

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  synchronous active-low reset
- coef_in  in  W_W*O_N  coefficient bus; slot i = coef_in[i*W_W +: W_W]
- coef_up  in  1  one-cycle strobe: coef_in is valid this cycle
- freeze  in  1  when high, coef_up is ignored and coefficients are held
- x_valid  in  1  input sample valid
- x_ready  out  1  block can accept a sample
- xin  in  X_W  input sample, signed
- y_valid  out  1  one-cycle pulse: yout is updated
- yout  out  Y_W  filtered output, signed, held between pulses
- busy  out  1  MAC sequence in progress

Behaviour:
- Reset: synchronous, active-low; single clock domain.
  - Sampled on the clk rising edge, with priority over everything else, including mid-MAC.
  - Clears the delay line, the active bank, the shadow bank, the pending flag, the accumulator and the tap counter.
  - Output reset values: yout=0, y_valid=0, x_ready=1, busy=0.
  - State returns to IDLE.
  - A sequence interrupted by reset never produces y_valid.
- States:
  - IDLE: x_ready=1, busy=0.
  - MAC: x_ready=0, busy=1.
  - OUT: x_ready=0, busy=1.
- IDLE -> MAC on x_valid & x_ready (acceptance). On the acceptance edge:
  - the delay line shifts: tap[i] <= tap[i-1] for i>0, and tap[0] <= xin;
  - if pending=1, the active bank <= shadow bank and pending is cleared;
  - acc <= 0 and the tap counter k <= 0.
- MAC: one product per cycle, acc <= acc + tap[k]*coef[k], for k = 0..O_N-1.
  - Products are signed, full width X_W+W_W, sign-extended to ACC_W.
  - After k=O_N-1, go to OUT.
- OUT, for one cycle:
  - yout <= sat(acc >>> SHIFT): truncation toward negative infinity, then clamp to [-2^(Y_W-1), 2^(Y_W-1)-1].
  - y_valid <= 1, then back to IDLE.
- Latency: acceptance at edge T gives y_valid high in the cycle after edge T+O_N+1, i.e. O_N+2 cycles (18 by default).
- Throughput: x_ready returns in the same cycle as y_valid. Back-to-back samples therefore sustain one per O_N+2 cycles.
- x_valid while x_ready=0 is not accepted. The source holds xin and x_valid until acceptance (valid/ready rule). No sample is dropped or duplicated.
- Coefficient update: coef_up & !freeze latches coef_in into the shadow bank and sets pending=1.
  - This can happen in any state.
  - The active bank never changes during MAC or OUT, so an output is always computed from a single coherent snapshot.
  - coef_up in the same cycle as acceptance goes to the shadow bank only and applies to the next sample. If pending was already set, the previously pending shadow is applied to the current sample.
  - Multiple coef_up strobes before the next acceptance: the last one wins.
  - coef_up while freeze=1: no effect on the shadow bank or pending. A pending flag set earlier remains set.
- y_valid is a single-cycle pulse. yout holds its value until the next OUT.

Test Plan:
- Impulse/tap order: active coef slot3=0x7FFF, all other slots 0; samples 0x7FFF,0,0,0 -> yout=0,0,0,0x7FFE. The 4th output is 32767*32767>>>15 = 32766. Each y_valid arrives exactly 18 cycles after its acceptance.
- Gain/latency: slot0=0x4000, others 0; xin=1000 -> yout=500. xin=-1001 -> yout=-501 (floor). x_ready is low for 17 cycles after acceptance.
- Saturation: all slots 0x7FFF; 16 samples of 0x7FFF -> final yout=0x7FFF (clamped). The same with 0x8000 samples -> yout=0x8000.
- Deferred update: slot0=0x4000; coef_up with slot0=0x2000 at cycle 5 of MAC on sample xin=800 -> current yout=400. Next sample xin=800 -> yout=200. A second coef_up (slot0=0x1000) issued before that next acceptance -> yout=100 instead (last one wins).
- Freeze: freeze=1, coef_up with slot0=0 -> yout unchanged from the prior coefficients. Then release freeze and strobe coef_up again -> new coefficients take effect on the next sample.
- Reset mid-MAC: rst_n low at MAC cycle 8 -> next cycle: x_ready=1, yout=0, no y_valid. The next sample sees an all-zero delay line and all-zero coefficients -> yout=0.
